// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: freezes on dcache waits,
// squashes on mem-stage redirects, bubbles load-use and icache misses, drains halts.
module pipeline_hazard_ctrl #(
   parameter int unsigned DRAIN_CYCLES = 3,
   parameter int unsigned CNT_W        = 32
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             ihit,
   input  logic             dhit,
   input  logic             mem_dren,
   input  logic             mem_dwen,
   input  logic             mem_redirect,
   input  logic             ex_dren,
   input  logic [4:0]       ex_wsel,
   input  logic [4:0]       dec_rs,
   input  logic [4:0]       dec_rt,
   input  logic             dec_uses_rt,
   input  logic             dec_halt,
   output logic             pc_en,
   output logic             fd_en,
   output logic             de_en,
   output logic             em_en,
   output logic             mw_en,
   output logic             fd_flush,
   output logic             de_flush,
   output logic             em_flush,
   output logic             halt,
   output logic [CNT_W-1:0] stall_cnt
);

   localparam int unsigned DW = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

   typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

   state_t           r_state, w_state_nxt;
   logic [DW-1:0]    r_drain, w_drain_nxt;
   logic [CNT_W-1:0] r_stall_cnt;
   logic             w_dwait, w_luse;

   assign w_dwait = (mem_dren | mem_dwen) & ~dhit;
   assign w_luse  = ex_dren & (ex_wsel != 5'd0) &
                    ((ex_wsel == dec_rs) | (dec_uses_rt & (ex_wsel == dec_rt)));

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_state <= RUN;
         r_drain <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_drain <= w_drain_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_drain_nxt = r_drain;
      pc_en       = 1'b0;
      fd_en       = 1'b0;
      de_en       = 1'b0;
      em_en       = 1'b0;
      mw_en       = 1'b0;
      fd_flush    = 1'b0;
      de_flush    = 1'b0;
      em_flush    = 1'b0;
      if (nRST) begin
         case (r_state)
            RUN, DRAIN: begin
               if (w_dwait) begin
                  // full freeze: mem holds, so a pending redirect is seen again next cycle
               end else if (mem_redirect) begin
                  {pc_en, fd_en, de_en, em_en, mw_en} = '1;
                  {fd_flush, de_flush, em_flush}      = '1;
                  if (r_state == DRAIN) begin
                     w_state_nxt = RUN;
                     w_drain_nxt = '0;
                  end
               end else if (r_state == DRAIN) begin
                  {fd_en, de_en, em_en, mw_en} = '1;
                  fd_flush    = 1'b1;
                  w_drain_nxt = r_drain - DW'(1);
                  if (r_drain == DW'(1))
                     w_state_nxt = HALTED;
               end else if (w_luse) begin
                  {de_en, em_en, mw_en} = '1;
                  de_flush = 1'b1;
               end else if (dec_halt | ~ihit) begin
                  {fd_en, de_en, em_en, mw_en} = '1;
                  fd_flush = 1'b1;
                  if (dec_halt) begin
                     w_state_nxt = DRAIN;
                     w_drain_nxt = DW'(DRAIN_CYCLES);
                  end
               end else begin
                  {pc_en, fd_en, de_en, em_en, mw_en} = '1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST)
         r_stall_cnt <= '0;
      else if (!pc_en && r_state != HALTED && r_stall_cnt != '1)
         r_stall_cnt <= r_stall_cnt + CNT_W'(1);
   end

   assign halt      = (r_state == HALTED);
   assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench: stimulus pushes model-predicted outputs per cycle,
// a negedge monitor pops and compares them against the DUT.
module tb_pipeline_hazard_ctrl;

   localparam int unsigned DC = 3;
   localparam int unsigned CW = 5;

   logic          CLK = 1'b0;
   logic          nRST = 1'b0;
   logic          ihit = 1'b1, dhit = 1'b1, mem_dren = 1'b0, mem_dwen = 1'b0;
   logic          mem_redirect = 1'b0, ex_dren = 1'b0, dec_uses_rt = 1'b0, dec_halt = 1'b0;
   logic [4:0]    ex_wsel = '0, dec_rs = '0, dec_rt = '0;
   logic          pc_en, fd_en, de_en, em_en, mw_en, fd_flush, de_flush, em_flush, halt;
   logic [CW-1:0] stall_cnt;

   always #5 CLK = ~CLK;

   pipeline_hazard_ctrl #(.DRAIN_CYCLES(DC), .CNT_W(CW)) dut (
      .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
      .mem_dren(mem_dren), .mem_dwen(mem_dwen), .mem_redirect(mem_redirect),
      .ex_dren(ex_dren), .ex_wsel(ex_wsel), .dec_rs(dec_rs), .dec_rt(dec_rt),
      .dec_uses_rt(dec_uses_rt), .dec_halt(dec_halt),
      .pc_en(pc_en), .fd_en(fd_en), .de_en(de_en), .em_en(em_en), .mw_en(mw_en),
      .fd_flush(fd_flush), .de_flush(de_flush), .em_flush(em_flush),
      .halt(halt), .stall_cnt(stall_cnt)
   );

   typedef struct {
      logic       rst, ih, dh, mdr, mdw, mred, exdr, urt, dhalt;
      logic [4:0] wsel, rs, rt;
   } stim_t;

   typedef struct {
      logic [7:0]    ctl;   // {pc,fd,de,em,mw,fd_fl,de_fl,em_fl}
      logic          halt;
      logic [CW-1:0] cnt;
   } exp_t;

   exp_t q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   // reference model state
   bit      m_halted   = 0;
   bit      m_draining = 0;
   int      m_left     = 0;
   longint  m_stall    = 0;
   longint  m_max      = (longint'(1) << CW) - 1;

   function automatic stim_t quiet();
      stim_t s;
      s.rst = 1; s.ih = 1; s.dh = 1; s.mdr = 0; s.mdw = 0; s.mred = 0;
      s.exdr = 0; s.urt = 0; s.dhalt = 0; s.wsel = 0; s.rs = 0; s.rt = 0;
      return s;
   endfunction

   task automatic cycle(input stim_t s);
      bit         dw, lu;
      logic [7:0] ctl;
      exp_t       e;
      @(posedge CLK);
      #1;
      nRST = s.rst; ihit = s.ih; dhit = s.dh; mem_dren = s.mdr; mem_dwen = s.mdw;
      mem_redirect = s.mred; ex_dren = s.exdr; ex_wsel = s.wsel; dec_rs = s.rs;
      dec_rt = s.rt; dec_uses_rt = s.urt; dec_halt = s.dhalt;

      dw = (s.mdr || s.mdw) && !s.dh;
      lu = s.exdr && s.wsel != 0 && (s.wsel == s.rs || (s.urt && s.wsel == s.rt));
      if (!s.rst || m_halted || dw)                 ctl = 8'b0000_0000;
      else if (s.mred)                              ctl = 8'b1111_1111;
      else if (m_draining)                          ctl = 8'b0111_1100;
      else if (lu)                                  ctl = 8'b0011_1010;
      else if (s.dhalt || !s.ih)                    ctl = 8'b0111_1100;
      else                                          ctl = 8'b1111_1000;

      e.ctl  = ctl;
      e.halt = s.rst && m_halted;
      e.cnt  = s.rst ? CW'(m_stall) : '0;
      q.push_back(e);

      if (!s.rst) begin
         m_halted = 0; m_draining = 0; m_left = 0; m_stall = 0;
      end else if (!m_halted) begin
         if (!ctl[7] && m_stall < m_max) m_stall++;
         if (dw) begin
         end else if (s.mred) begin
            m_draining = 0;
         end else if (m_draining) begin
            m_left--;
            if (m_left == 0) begin
               m_draining = 0;
               m_halted   = 1;
            end
         end else if (!lu && s.dhalt) begin
            m_draining = 1;
            m_left     = DC;
         end
      end
   endtask

   task automatic run_quiet(input int n);
      for (int i = 0; i < n; i++) cycle(quiet());
   endtask

   task automatic do_reset();
      stim_t s;
      s = quiet();
      s.rst = 0;
      cycle(s);
      cycle(s);
   endtask

   always @(negedge CLK) begin
      exp_t e;
      logic [7:0] act;
      if (q.size() > 0) begin
         e   = q.pop_front();
         act = {pc_en, fd_en, de_en, em_en, mw_en, fd_flush, de_flush, em_flush};
         n_tests++;
         if (act !== e.ctl) begin
            n_fail++;
            $display("FAIL ctl t=%0t actual=%b required=%b", $time, act, e.ctl);
         end
         n_tests++;
         if (halt !== e.halt) begin
            n_fail++;
            $display("FAIL halt t=%0t actual=%b required=%b", $time, halt, e.halt);
         end
         n_tests++;
         if (stall_cnt !== e.cnt) begin
            n_fail++;
            $display("FAIL stall_cnt t=%0t actual=%0d required=%0d", $time, stall_cnt, e.cnt);
         end
      end
   end

   initial begin
      stim_t s;
      do_reset();
      run_quiet(10);

      // load-use on rs, then register 0, then rt with/without dec_uses_rt
      s = quiet(); s.exdr = 1; s.wsel = 5; s.rs = 5; cycle(s);
      run_quiet(2);
      s = quiet(); s.exdr = 1; s.wsel = 0; s.rs = 0; cycle(s);
      s = quiet(); s.exdr = 1; s.wsel = 7; s.rs = 3; s.rt = 7; s.urt = 1; cycle(s);
      s.urt = 0; cycle(s);
      run_quiet(2);

      // dcache wait, then with a redirect pending during the wait
      s = quiet(); s.mdw = 1; s.dh = 0;
      repeat (4) cycle(s);
      s.dh = 1; cycle(s);
      run_quiet(2);
      s = quiet(); s.mdr = 1; s.dh = 0; s.mred = 1;
      repeat (3) cycle(s);
      s.dh = 1; cycle(s);
      run_quiet(2);

      // redirect beats load-use and icache miss
      s = quiet(); s.mred = 1; s.exdr = 1; s.wsel = 5; s.rs = 5; s.ih = 0; cycle(s);
      s = quiet(); s.exdr = 1; s.wsel = 9; s.rs = 9; s.ih = 0; cycle(s);
      run_quiet(2);

      // clean halt, then asynchronous reset while halted
      s = quiet(); s.dhalt = 1; cycle(s);
      run_quiet(24);
      do_reset();
      run_quiet(2);

      // halt with one dcache wait mid-drain
      s = quiet(); s.dhalt = 1; cycle(s);
      run_quiet(1);
      s = quiet(); s.mdw = 1; s.dh = 0; cycle(s);
      run_quiet(24);
      do_reset();

      // halt squashed by a redirect; then halt blocked by load-use
      s = quiet(); s.dhalt = 1; cycle(s);
      run_quiet(1);
      s = quiet(); s.mred = 1; cycle(s);
      run_quiet(6);
      s = quiet(); s.dhalt = 1; s.exdr = 1; s.wsel = 4; s.rs = 4; cycle(s);
      s = quiet(); s.dhalt = 1; cycle(s);
      run_quiet(8);
      do_reset();

      for (int i = 0; i < 3000; i++) begin
         s       = quiet();
         s.ih    = $urandom_range(0, 9) != 0;
         s.dh    = $urandom_range(0, 2) != 0;
         s.mdr   = $urandom_range(0, 4) == 0;
         s.mdw   = $urandom_range(0, 4) == 0;
         s.mred  = $urandom_range(0, 9) == 0;
         s.exdr  = $urandom_range(0, 2) == 0;
         s.wsel  = 5'($urandom_range(0, 3));
         s.rs    = 5'($urandom_range(0, 3));
         s.rt    = 5'($urandom_range(0, 3));
         s.urt   = 1'($urandom_range(0, 1));
         s.dhalt = $urandom_range(0, 24) == 0;
         s.rst   = m_halted ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 299) != 0);
         cycle(s);
      end

      for (int k = 0; k < 10 && q.size() != 0; k++) @(negedge CLK);
      #1;
      n_tests++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL drain_queue actual=%0d required=0", q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
